cache_refill_ctrl: RTL and testbench

Miss-handling stage directly downstream of `fully_associative_cache`. It accepts one miss request at a time, optionally writes back a dirty victim line, and then fetches the missing block from byte-wide main memory. It assembles the block into a full line and hands it to the cache with a one-cycle fill pulse. All memory traffic is byte-granular over a valid/ready request channel with an in-order response channel.

---
 rtl/cache_pkg.sv | 14 +
 rtl/cache_refill_ctrl.sv | 130 +++++++++++++
 tb/tb_cache_refill_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss path: default geometry and refill FSM states.
package cache_pkg;

  localparam int BLOCK_SIZE_DEFAULT = 16;
  localparam int OFFSET_BITS        = $clog2(BLOCK_SIZE_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss handler: optional byte-wise victim writeback, then byte-wise block fetch,
// delivered to the cache as a single-cycle fill pulse.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int BLOCK_SIZE = cache_pkg::BLOCK_SIZE_DEFAULT,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wb,
  input  logic [ADDR_WIDTH-1:0]   req_wb_addr,
  input  logic [8*BLOCK_SIZE-1:0] req_wb_line,
  output logic                    fill_valid,
  output logic [ADDR_WIDTH-1:0]   fill_addr,
  output logic [8*BLOCK_SIZE-1:0] fill_line,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [7:0]              mem_req_wdata,
  input  logic                    mem_rsp_valid,
  input  logic [7:0]              mem_rsp_data
);

  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int CNT_W = OFF_W + 1;

  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(BLOCK_SIZE);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BLOCK_SIZE - 1));

  refill_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] base, wb_base;
  logic [CNT_W-1:0]      wcnt, icnt, rcnt;
  logic [7:0]            wb_buf   [BLOCK_SIZE];
  logic [7:0]            line_buf [BLOCK_SIZE];

  logic accept, mem_hs;

  assign accept = req_valid && req_ready;
  assign mem_hs = mem_req_valid && mem_req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // All request-side outputs decode from state and counters only, so no
  // memory response can reach the request channel in the same cycle.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    fill_valid    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_wb ? WB : RD;
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = wb_base + ADDR_WIDTH'(wcnt);
        mem_req_wdata = wb_buf[wcnt[OFF_W-1:0]];
        if (mem_req_ready && wcnt == CNT_LAST) state_nxt = RD;
      end
      RD: begin
        mem_req_valid = (icnt < CNT_FULL);
        mem_req_addr  = base + ADDR_WIDTH'(icnt);
        if (mem_rsp_valid && rcnt == CNT_LAST) state_nxt = FILL;
      end
      FILL: begin
        fill_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base    <= '0;
      wb_base <= '0;
      wcnt    <= '0;
      icnt    <= '0;
      rcnt    <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        wb_buf[i]   <= '0;
        line_buf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (accept) begin
          base    <= req_addr & ALIGN_MASK;
          wb_base <= req_wb_addr & ALIGN_MASK;
          wcnt    <= '0;
          icnt    <= '0;
          rcnt    <= '0;
          for (int i = 0; i < BLOCK_SIZE; i++) wb_buf[i] <= req_wb_line[8*i +: 8];
        end
        WB: if (mem_hs) wcnt <= wcnt + CNT_ONE;
        // Issue and receive advance independently; responses land in arrival order.
        RD: begin
          if (mem_hs) icnt <= icnt + CNT_ONE;
          if (mem_rsp_valid) begin
            line_buf[rcnt[OFF_W-1:0]] <= mem_rsp_data;
            rcnt                      <= rcnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign fill_addr = base;

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_fill
    assign fill_line[8*g +: 8] = line_buf[g];
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a byte-wide memory model driven on the falling edge.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         req_wb = 1'b0;
  logic [31:0]  req_wb_addr = '0;
  logic [127:0] req_wb_line = '0;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] fill_line;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b1;
  logic         mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [7:0]   mem_req_wdata;
  logic         mem_rsp_valid = 1'b0;
  logic [7:0]   mem_rsp_data = '0;

  cache_refill_ctrl #(.BLOCK_SIZE(16), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_line(req_wb_line),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model knobs
  int rdy_mode = 0;
  int lat = 1;
  bit spur = 1'b0;

  logic [31:0]  log_addr[$];
  logic         log_we[$];
  logic [7:0]   log_wd[$];
  int           pend_cyc[$];
  logic [7:0]   pend_dat[$];
  int           fill_cyc_q[$];
  logic [31:0]  fill_addr_q[$];
  logic [127:0] fill_line_q[$];
  int           acc_q[$];
  int           rsp_cnt = 0;
  int           last_rsp_cyc = 0;
  int           stab_err = 0;
  int           stall_cnt = 0;
  logic         stalled = 1'b0;
  logic [31:0]  st_addr = '0;
  logic         st_we = 1'b0;
  logic [7:0]   st_wd = '0;

  // Falling edge: choose this cycle's ready/response, then record what the
  // DUT presents; the matching handshakes complete at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      pend_cyc.delete();
      pend_dat.delete();
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      stalled = 1'b0;
    end else begin
      mem_req_ready = (rdy_mode == 0) ? 1'b1 : cyc[0];
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 8'h00;
      if (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pend_dat.pop_front();
        void'(pend_cyc.pop_front());
        rsp_cnt++;
        last_rsp_cyc = cyc;
      end else if (spur && req_ready) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 8'hEE;
      end
      if (stalled && (!mem_req_valid || mem_req_addr != st_addr ||
                      mem_req_we != st_we || mem_req_wdata != st_wd))
        stab_err++;
      if (mem_req_valid && mem_req_ready) begin
        log_addr.push_back(mem_req_addr);
        log_we.push_back(mem_req_we);
        log_wd.push_back(mem_req_wdata);
        if (!mem_req_we) begin
          pend_cyc.push_back(cyc + lat);
          pend_dat.push_back(mem_req_addr[7:0]);
        end
        stalled = 1'b0;
      end else if (mem_req_valid) begin
        stalled = 1'b1;
        st_addr = mem_req_addr;
        st_we   = mem_req_we;
        st_wd   = mem_req_wdata;
        stall_cnt++;
      end else begin
        stalled = 1'b0;
      end
      if (fill_valid) begin
        fill_cyc_q.push_back(cyc);
        fill_addr_q.push_back(fill_addr);
        fill_line_q.push_back(fill_line);
      end
      if (req_valid && req_ready) acc_q.push_back(cyc);
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_we.delete(); log_wd.delete();
    fill_cyc_q.delete(); fill_addr_q.delete(); fill_line_q.delete();
    acc_q.delete();
    rsp_cnt = 0; stab_err = 0; stall_cnt = 0;
  endtask

  task automatic start_req(input logic [31:0] a, input logic wb,
                           input logic [31:0] wa, input logic [127:0] wl);
    @(posedge clk); #2;
    req_valid = 1'b1; req_addr = a; req_wb = wb; req_wb_addr = wa; req_wb_line = wl;
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_fill(input int n);
    int k = 0;
    while (fill_cyc_q.size() < n && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (fill_cyc_q.size() < n) begin
      errors++;
      $display("FAIL fill_timeout: fills seen %0d, required %0d", fill_cyc_q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %b want 0", mem_req_valid); end
    checks++; if (mem_req_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_req_we); end
    checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL rst_fill_valid: got %b want 0", fill_valid); end
    checks++; if (fill_addr !== 32'h0) begin errors++; $display("FAIL rst_fill_addr: got %h want 0", fill_addr); end
    checks++; if (fill_line !== 128'h0) begin errors++; $display("FAIL rst_fill_line: got %h want 0", fill_line); end
    @(posedge clk); #2; reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle: ready %b valid %b want 1 0", req_ready, mem_req_valid);
    end
  endtask

  task automatic test_clean_miss();
    logic [127:0] exp;
    clear_logs(); rdy_mode = 0; lat = 1; spur = 1'b0;
    for (int i = 0; i < 16; i++) exp[8*i +: 8] = 8'h30 + 8'(i);
    start_req(32'h0000_1234, 1'b0, 32'h0, 128'h0);
    wait_fill(1);
    repeat (5) @(negedge clk);
    checks++; if (log_addr.size() !== 16) begin errors++; $display("FAIL clean_nreq: got %0d want 16", log_addr.size()); end
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== 32'h1230 + i || log_we[i] !== 1'b0) begin
        errors++; $display("FAIL clean_rd[%0d]: got %h we %b want %h we 0", i, log_addr[i], log_we[i], 32'h1230 + i);
      end
    end
    checks++; if (fill_cyc_q.size() !== 1) begin errors++; $display("FAIL clean_npulse: got %0d want 1", fill_cyc_q.size()); end
    if (fill_cyc_q.size() > 0 && acc_q.size() > 0) begin
      checks++; if (fill_cyc_q[0] - acc_q[0] !== 18) begin errors++; $display("FAIL clean_lat: got %0d want 18", fill_cyc_q[0] - acc_q[0]); end
      checks++; if (fill_addr_q[0] !== 32'h0000_1230) begin errors++; $display("FAIL clean_addr: got %h want 00001230", fill_addr_q[0]); end
      checks++; if (fill_line_q[0] !== exp) begin errors++; $display("FAIL clean_line: got %h want %h", fill_line_q[0], exp); end
    end
  endtask

  task automatic test_dirty_victim();
    logic [127:0] wl, exp;
    clear_logs(); rdy_mode = 0; lat = 1; spur = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wl[8*i +: 8]  = 8'hA0 + 8'(i);
      exp[8*i +: 8] = 8'(i);
    end
    start_req(32'h0000_2000, 1'b1, 32'h0000_FFF0, wl);
    wait_fill(1);
    repeat (3) @(negedge clk);
    checks++; if (log_addr.size() !== 32) begin errors++; $display("FAIL dirty_nreq: got %0d want 32", log_addr.size()); end
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== 32'hFFF0 + i || log_we[i] !== 1'b1 || log_wd[i] !== 8'hA0 + 8'(i)) begin
        errors++; $display("FAIL dirty_wr[%0d]: got %h we %b d %h want %h we 1 d %h",
                           i, log_addr[i], log_we[i], log_wd[i], 32'hFFF0 + i, 8'hA0 + 8'(i));
      end
    end
    for (int i = 16; i < 32 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== 32'h2000 + (i - 16) || log_we[i] !== 1'b0) begin
        errors++; $display("FAIL dirty_rd[%0d]: got %h we %b want %h we 0", i, log_addr[i], log_we[i], 32'h2000 + (i - 16));
      end
    end
    if (fill_cyc_q.size() > 0 && acc_q.size() > 0) begin
      checks++; if (fill_cyc_q[0] - acc_q[0] !== 34) begin errors++; $display("FAIL dirty_lat: got %0d want 34", fill_cyc_q[0] - acc_q[0]); end
      checks++; if (fill_addr_q[0] !== 32'h2000 || fill_line_q[0] !== exp) begin
        errors++; $display("FAIL dirty_fill: got %h %h want 00002000 %h", fill_addr_q[0], fill_line_q[0], exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] wl, exp;
    clear_logs(); rdy_mode = 1; lat = 3; spur = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wl[8*i +: 8]  = 8'hC0 + 8'(i);
      exp[8*i +: 8] = 8'h60 + 8'(i);
    end
    start_req(32'h0000_4567, 1'b1, 32'h0000_8A5C, wl);
    wait_fill(1);
    repeat (3) @(negedge clk);
    checks++; if (log_addr.size() !== 32) begin errors++; $display("FAIL bp_nreq: got %0d want 32", log_addr.size()); end
    for (int i = 0; i < 32 && i < log_addr.size(); i++) begin
      logic [31:0] ea;
      ea = (i < 16) ? 32'h8A50 + i : 32'h4560 + (i - 16);
      checks++;
      if (log_addr[i] !== ea || log_we[i] !== (i < 16) || (i < 16 && log_wd[i] !== 8'hC0 + 8'(i))) begin
        errors++; $display("FAIL bp_req[%0d]: got %h we %b d %h want %h", i, log_addr[i], log_we[i], log_wd[i], ea);
      end
    end
    checks++; if (stall_cnt == 0) begin errors++; $display("FAIL bp_stalls: got 0 stalled cycles want >0"); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_err); end
    if (fill_cyc_q.size() > 0) begin
      checks++; if (fill_cyc_q[0] !== last_rsp_cyc + 1) begin
        errors++; $display("FAIL bp_fill_cyc: got %0d want %0d", fill_cyc_q[0], last_rsp_cyc + 1);
      end
      checks++; if (fill_addr_q[0] !== 32'h4560 || fill_line_q[0] !== exp) begin
        errors++; $display("FAIL bp_fill: got %h %h want 00004560 %h", fill_addr_q[0], fill_line_q[0], exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    clear_logs(); rdy_mode = 0; lat = 1; spur = 1'b1;
    for (int i = 0; i < 16; i++) exp[8*i +: 8] = 8'(i);
    repeat (3) @(posedge clk);
    #2; req_valid = 1'b1; req_addr = 32'h0000_5000; req_wb = 1'b0;
    wait_fill(1);
    @(posedge clk); #2;
    @(posedge clk); #2; req_valid = 1'b0;
    wait_fill(2);
    repeat (3) @(negedge clk);
    spur = 1'b0;
    checks++; if (acc_q.size() !== 2) begin errors++; $display("FAIL b2b_naccept: got %0d want 2", acc_q.size()); end
    if (acc_q.size() >= 2) begin
      checks++; if (acc_q[1] - acc_q[0] !== 19) begin errors++; $display("FAIL b2b_gap: got %0d want 19", acc_q[1] - acc_q[0]); end
    end
    if (fill_cyc_q.size() >= 2) begin
      checks++; if (fill_line_q[1] !== exp || fill_addr_q[1] !== 32'h5000) begin
        errors++; $display("FAIL b2b_line: got %h %h want 00005000 %h", fill_addr_q[1], fill_line_q[1], exp);
      end
    end
  endtask

  task automatic test_reset_mid_rd();
    logic [127:0] exp;
    int k = 0;
    clear_logs(); rdy_mode = 0; lat = 1; spur = 1'b0;
    for (int i = 0; i < 16; i++) exp[8*i +: 8] = 8'(i);
    start_req(32'h0000_7000, 1'b0, 32'h0, 128'h0);
    while (rsp_cnt < 5 && k < 100) begin @(negedge clk); #1; k++; end
    checks++; if (rsp_cnt < 5) begin errors++; $display("FAIL mid_rsp_timeout: got %0d responses want 5", rsp_cnt); end
    @(posedge clk); #2; reset = 1'b1; #1;
    checks++; if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_req_we !== 1'b0) begin
      errors++; $display("FAIL mid_rst_mem: ready %b valid %b we %b want 1 0 0", req_ready, mem_req_valid, mem_req_we);
    end
    checks++; if (fill_valid !== 1'b0 || fill_addr !== 32'h0 || fill_line !== 128'h0) begin
      errors++; $display("FAIL mid_rst_fill: valid %b addr %h line %h want 0 0 0", fill_valid, fill_addr, fill_line);
    end
    repeat (3) @(posedge clk); #2; reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (fill_cyc_q.size() !== 0) begin errors++; $display("FAIL mid_no_fill: got %0d pulses want 0", fill_cyc_q.size()); end
    clear_logs();
    start_req(32'h0000_3000, 1'b0, 32'h0, 128'h0);
    wait_fill(1);
    if (fill_cyc_q.size() > 0 && acc_q.size() > 0) begin
      checks++; if (fill_cyc_q[0] - acc_q[0] !== 18) begin errors++; $display("FAIL after_rst_lat: got %0d want 18", fill_cyc_q[0] - acc_q[0]); end
      checks++; if (fill_addr_q[0] !== 32'h3000 || fill_line_q[0] !== exp) begin
        errors++; $display("FAIL after_rst_fill: got %h %h want 00003000 %h", fill_addr_q[0], fill_line_q[0], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_victim();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_rd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
